// File: rtl/ieee754_encoder.sv
// Packs sign/exp/frac+GRS into IEEE-754 single or half (bits [15:0]) with round-nearest-even; IEEE754_FTZ_EN enables flush-to-zero.
// Latency special 1 / normal 2 / half subnormal 2+n cycles; result held in DONE until out_ready, in_ready only in IDLE.
module ieee754_encoder #(
  parameter int SHIFT_CAP = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode_fp,
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [22:0] frac,
  input  logic [2:0]  grs,
  input  logic        is_nan,
  input  logic        is_inf,
  input  logic        is_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam int CW = $clog2(SHIFT_CAP + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  typedef struct packed {
    logic        mode;
    logic        sign;
    logic        ovf;
    logic        flush;
    logic [7:0]  exp;
    logic        hid;
    logic [22:0] mant;
    logic        g;
    logic        r;
    logic        s;
  } op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fp_out_q, fp_out_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          inexact_q, inexact_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic signed [9:0] e_h, sh_amt;
  logic [CW-1:0]     n_load;
  logic              accept, special, inc, inx_r;
  logic [23:0]       sum_s;
  logic [8:0]        exp_s;
  logic [10:0]       sum_h;
  logic [5:0]        exp_h;
  logic [31:0]       special_pat;

  assign e_h    = $signed({2'b00, exp}) - 10'sd112;
  assign sh_amt = 10'sd1 - e_h;
  assign n_load = (sh_amt > $signed(10'(SHIFT_CAP))) ? CW'(SHIFT_CAP) : sh_amt[CW-1:0];

  assign accept  = in_valid && in_ready_q;
  assign special = is_nan || is_inf || is_zero;

  always_comb begin
    if (is_nan)
      special_pat = mode_fp ? {sign, 8'hFF, 1'b1, 22'b0} : {16'b0, sign, 5'h1F, 1'b1, 9'b0};
    else if (is_inf)
      special_pat = mode_fp ? {sign, 8'hFF, 23'b0} : {16'b0, sign, 5'h1F, 10'b0};
    else
      special_pat = mode_fp ? {sign, 31'b0} : {16'b0, sign, 15'b0};
  end

  // Half operands keep their 10-bit mantissa right-aligned so one lsb/G/R/S rule serves both formats.
  assign inc   = op_q.g && (op_q.r || op_q.s || op_q.mant[0]);
  assign inx_r = op_q.g || op_q.r || op_q.s;
  assign sum_s = {1'b0, op_q.mant} + {23'b0, inc};
  assign exp_s = {1'b0, op_q.exp} + {8'b0, sum_s[23]};
  assign sum_h = {1'b0, op_q.mant[9:0]} + {10'b0, inc};
  assign exp_h = {1'b0, op_q.exp[4:0]} + {5'b0, sum_h[10]};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    fp_out_d    = fp_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = '0;
          op_d.mode = mode_fp;
          op_d.sign = sign;
          op_d.hid  = (exp != 8'd0);
          cnt_d     = n_load;
          if (special) begin
            fp_out_d    = special_pat;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            inexact_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (mode_fp) begin
            op_d.exp                      = exp;
            op_d.mant                     = frac;
            {op_d.g, op_d.r, op_d.s}      = grs;
            op_d.ovf                      = (exp == 8'hFF);
`ifdef IEEE754_FTZ_EN
            op_d.flush                    = (exp == 8'd0) && (frac != 23'd0);
`endif
            state_d                       = ROUND;
          end else begin
            op_d.mant = {13'b0, frac[22:13]};
            op_d.g    = frac[12];
            op_d.r    = frac[11];
            op_d.s    = |frac[10:0] || |grs;
            if (e_h >= 10'sd31) begin
              op_d.ovf = 1'b1;
              state_d  = ROUND;
            end else if (e_h <= 10'sd0) begin
`ifdef IEEE754_FTZ_EN
              op_d.flush = 1'b1;
              state_d    = ROUND;
`else
              state_d    = ALIGN;
`endif
            end else begin
              op_d.exp = e_h[7:0];
              state_d  = ROUND;
            end
          end
        end
      end
      ALIGN: begin
        op_d.hid       = 1'b0;
        op_d.mant[9:0] = {op_q.hid, op_q.mant[9:1]};
        op_d.g         = op_q.mant[0];
        op_d.r         = op_q.g;
        op_d.s         = op_q.s || op_q.r;
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q <= CW'(1))
          state_d = ROUND;
      end
      ROUND: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        overflow_d  = 1'b0;
        inexact_d   = inx_r;
        underflow_d = inx_r && (op_q.exp == 8'd0);
        if (op_q.flush) begin
          fp_out_d    = op_q.mode ? {op_q.sign, 31'b0} : {16'b0, op_q.sign, 15'b0};
          underflow_d = 1'b1;
          inexact_d   = 1'b1;
        end else if (op_q.mode) begin
          fp_out_d = {op_q.sign, exp_s[7:0], sum_s[22:0]};
          if (op_q.ovf || exp_s >= 9'd255) begin
            fp_out_d    = {op_q.sign, 8'hFF, 23'b0};
            overflow_d  = 1'b1;
            underflow_d = 1'b0;
            inexact_d   = 1'b1;
          end
        end else begin
          fp_out_d = {16'b0, op_q.sign, exp_h[4:0], sum_h[9:0]};
          if (op_q.ovf || exp_h >= 6'd31) begin
            fp_out_d    = {16'b0, op_q.sign, 5'h1F, 10'b0};
            overflow_d  = 1'b1;
            underflow_d = 1'b0;
            inexact_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      fp_out_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      fp_out_q    <= fp_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign fp_out    = fp_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule
